// File: rtl/lanes_pkg.sv
// lanes_pkg: speed encodings, symbol lengths and controller states shared by the
// two-lane receive sequencing controller and its symbol counter.
package lanes_pkg;

    typedef enum logic [1:0] {
        GEN4     = 2'b00,
        GEN3     = 2'b01,
        GEN2     = 2'b10,
        GEN4_ALT = 2'b11
    } gen_speed_e;

    localparam logic [7:0] SYM_LEN_GEN4 = 8'd8;
    localparam logic [7:0] SYM_LEN_GEN3 = 8'd132;
    localparam logic [7:0] SYM_LEN_GEN2 = 8'd66;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        DRAIN,
        SETTLE
    } rx_state_e;

    // Symbol length in bits for a deserializer speed; the reserved code runs as Gen4.
    function automatic logic [7:0] max_len(input logic [1:0] speed);
        logic [7:0] len;
        case (gen_speed_e'(speed))
            GEN3:    len = SYM_LEN_GEN3;
            GEN2:    len = SYM_LEN_GEN2;
            default: len = SYM_LEN_GEN4;
        endcase
        return len;
    endfunction

    // Fold the reserved code onto Gen4 so speed comparisons see a single value.
    function automatic logic [1:0] canon_speed(input logic [1:0] req);
        logic [1:0] spd;
        spd = req;
        if (req == GEN4_ALT) begin
            spd = GEN4;
        end
        return spd;
    endfunction

endpackage

// File: rtl/lanes_rx_bitcnt.sv
// lanes_rx_bitcnt: bit position within the current symbol, word strobe and
// descrambler seed-reset strobe. The first word after a clear is partial and is
// swallowed; word strobes start at the second symbol boundary.
module lanes_rx_bitcnt
    import lanes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       clr_i,
    input  logic [1:0] gen_speed_i,
    output logic [7:0] bit_cnt_o,
    output logic       last_bit_o,
    output logic       word_valid_o,
    output logic       descr_seed_rst_o
);

    logic [7:0] bit_cnt_q, bit_cnt_d;
    logic       wrapped_q, wrapped_d;   // at least one symbol wrap since the last clear
    logic       primed_q,  primed_d;    // partial first word has been passed over
    logic [7:0] last_idx;
    logic [7:0] seed_idx;

    // Next-state decode for the symbol counter and its priming flags
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        last_idx  = max_len(gen_speed_i) - 8'd1;
        seed_idx  = max_len(gen_speed_i) - 8'd2;
        bit_cnt_d = bit_cnt_q;
        wrapped_d = wrapped_q;
        primed_d  = primed_q;
        if (clr_i) begin
            bit_cnt_d = '0;
            wrapped_d = 1'b0;
            primed_d  = 1'b0;
        end else if (en_i) begin
            if (bit_cnt_q == last_idx) begin
                bit_cnt_d = '0;
                wrapped_d = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 8'd1;
            end
            // The boundary right after the first wrap closes the partial word; later ones deliver.
            if ((bit_cnt_q == 8'd0) && wrapped_q) begin
                primed_d = 1'b1;
            end
        end
    end

    // Counter flops; async reset returns to the start of a symbol, unprimed
    // NOTE: sequential state uses non-blocking (<=) so each flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q <= '0;
            wrapped_q <= 1'b0;
            primed_q  <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            wrapped_q <= wrapped_d;
            primed_q  <= primed_d;
        end
    end

    assign bit_cnt_o        = bit_cnt_q;
    assign last_bit_o       = en_i && (bit_cnt_q == last_idx);
    assign word_valid_o     = en_i && primed_q && (bit_cnt_q == 8'd0);
    assign descr_seed_rst_o = en_i && (bit_cnt_q == seed_idx);

endmodule

// File: rtl/lanes_rx_ctrl.sv
// lanes_rx_ctrl: sequences the two-lane receive deserializer. Owns the speed the
// deserializer runs at and changes it glitch-free: finish the current symbol,
// disable, settle, re-arm at the new speed. Also counts delivered words.
module lanes_rx_ctrl
    import lanes_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned SYM_CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 link_up,
    input  logic [1:0]           gen_speed_req,
    input  logic                 speed_chg,
    output logic                 des_enable,
    output logic [1:0]           des_gen_speed,
    output logic [7:0]           bit_cnt,
    output logic                 word_valid,
    output logic                 descr_seed_rst,
    output logic                 speed_chg_ack,
    output logic [SYM_CNT_W-1:0] sym_count,
    output logic                 busy
);

    localparam int unsigned         SETTLE_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    rx_state_e              state_q, state_d;
    logic [1:0]             pending_q, pending_d;     // speed to load on the next ARM
    logic [1:0]             speed_q, speed_d;         // speed the deserializer runs at
    logic [SETTLE_W-1:0]    settle_cnt_q, settle_cnt_d;
    logic [SYM_CNT_W-1:0]   sym_count_q, sym_count_d;
    logic                   ack_q, ack_d;
    logic                   from_settle_q, from_settle_d; // current ARM follows a speed change

    logic [1:0]             req_c;
    logic                   settle_done;
    logic                   last_bit;
    logic                   cnt_clr;

    assign req_c       = canon_speed(gen_speed_req);
    assign settle_done = (settle_cnt_q == SETTLE_LAST);
    assign cnt_clr     = !link_up || !des_enable;

    lanes_rx_bitcnt u_bitcnt (
        .clk              (clk),
        .rst              (rst),
        .en_i             (des_enable),
        .clr_i            (cnt_clr),
        .gen_speed_i      (speed_q),
        .bit_cnt_o        (bit_cnt),
        .last_bit_o       (last_bit),
        .word_valid_o     (word_valid),
        .descr_seed_rst_o (descr_seed_rst)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: link loss overrides everything, including a coincident speed change
    always_comb begin
        state_d = state_q;
        if (!link_up) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ARM;
                ARM:     state_d = RUN;
                RUN:     if (speed_chg && (req_c != speed_q)) state_d = DRAIN;
                DRAIN:   if (last_bit) state_d = SETTLE;
                SETTLE:  if (settle_done) state_d = ARM;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs decoded from the current state
    always_comb begin
        des_enable = 1'b0;
        busy       = 1'b0;
        case (state_q)
            RUN:     des_enable = 1'b1;
            DRAIN:   begin des_enable = 1'b1; busy = 1'b1; end
            ARM:     busy = 1'b1;
            SETTLE:  busy = 1'b1;
            default: ;
        endcase
    end

    // Speed bookkeeping, settle timer, word counter and acknowledge pulse
    always_comb begin
        pending_d     = pending_q;
        speed_d       = speed_q;
        settle_cnt_d  = '0;
        sym_count_d   = sym_count_q;
        ack_d         = 1'b0;
        from_settle_d = 1'b0;
        if (!link_up) begin
            sym_count_d = '0;
        end else begin
            // Requests are taken in every state but IDLE, where the request level is sampled instead.
            if (state_q == IDLE) begin
                pending_d = req_c;
            end else if (speed_chg) begin
                pending_d = req_c;
            end
            // The deserializer speed only moves in ARM, where des_enable is low.
            if (state_q == ARM) begin
                speed_d = pending_d;
                ack_d   = from_settle_q;
            end
            if ((state_q == RUN) && speed_chg && (req_c == speed_q)) begin
                ack_d = 1'b1;
            end
            if ((state_q == SETTLE) && !settle_done) begin
                settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
            end
            from_settle_d = (state_q == SETTLE) && settle_done;
            if ((state_q == IDLE) || (state_q == ARM)) begin
                sym_count_d = '0;
            end else if (word_valid && (sym_count_q != {SYM_CNT_W{1'b1}})) begin
                sym_count_d = sym_count_q + SYM_CNT_W'(1);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q     <= 2'b00;
            speed_q       <= 2'b00;
            settle_cnt_q  <= '0;
            sym_count_q   <= '0;
            ack_q         <= 1'b0;
            from_settle_q <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            speed_q       <= speed_d;
            settle_cnt_q  <= settle_cnt_d;
            sym_count_q   <= sym_count_d;
            ack_q         <= ack_d;
            from_settle_q <= from_settle_d;
        end
    end

    assign des_gen_speed = speed_q;
    assign speed_chg_ack = ack_q;
    assign sym_count     = sym_count_q;

endmodule
